// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream (4-byte word count, then words)
// into 32-bit instruction-memory writes and holds the core in reset until the image is in.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd4,
    parameter int          MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err,
    output logic [31:0] words_loaded
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    typedef enum logic [1:0] {HDR, DATA, DONE, ERR} state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic [31:0] n_words;
    logic [31:0] full_word;
    logic        finishing;
    logic        take;

    assign in_ready  = (state == HDR) || (state == DATA);
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign core_rst  = (state != DONE);
    assign full_word = {in_data, partial};

    // The cycle carrying the final write still shows in_ready, but a byte offered
    // then lies beyond the image and is dropped.
    assign finishing = (state == DATA) && mem_we && (words_loaded == n_words);
    assign take      = in_valid && in_ready && !finishing;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_next = state;
        case (state)
            HDR: begin
                if (take && byte_cnt == 2'd3) begin
                    if (full_word == 32'd0 || full_word > MAX_N)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (finishing)
                    state_next = DONE;
            end
            default: state_next = state;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HDR;
            byte_cnt     <= 2'd0;
            partial      <= 24'd0;
            n_words      <= 32'd0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            words_loaded <= 32'd0;
        end else begin
            state  <= state_next;
            mem_we <= 1'b0;
            if (take) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    partial[7:0]   <= in_data;
                    2'd1:    partial[15:8]  <= in_data;
                    2'd2:    partial[23:16] <= in_data;
                    default: begin
                        if (state == HDR) begin
                            n_words <= full_word;
                        end else begin
                            mem_we       <= 1'b1;
                            mem_addr     <= BASE_ADDR + (words_loaded << 2);
                            mem_wdata    <= full_word;
                            words_loaded <= words_loaded + 32'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: header table, randomized images against a
// queue-based reference, and hand sequences for gaps, reset mid-word and post-done input.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'd4;
    localparam int          MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;
    logic [31:0] words_loaded;

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst(core_rst), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] img[$];
    logic        prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            check("we_spacing", {31'd0, prev_we}, 32'd0);
        end
        prev_we = mem_we;
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rst", {31'd0, core_rst}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_words", words_loaded, 32'd0);
        rst = 1'b0;
        obs_addr.delete();
        obs_data.delete();
    endtask

    // Returns #1 after the edge that accepted the byte, with in_valid already low.
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int t = 0;
        repeat ($urandom_range(0, gap_max)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        while (!in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_max);
    endtask

    // Reference: a legal header yields writes BASE+4*i <- img[i]; completion flags two cycles on.
    task automatic run_load(input logic [31:0] n, input logic exp_err, input int gap_max);
        send_word(n, gap_max);
        if (exp_err) begin
            check("hdr_err", {31'd0, err}, 32'd1);
            check("hdr_err_ready", {31'd0, in_ready}, 32'd0);
            check("hdr_err_core_rst", {31'd0, core_rst}, 32'd1);
            repeat (6) @(posedge clk);
            #1;
            check("hdr_err_writes", 32'(obs_addr.size()), 32'd0);
            check("hdr_err_sticky", {31'd0, err}, 32'd1);
            check("hdr_err_done", {31'd0, done}, 32'd0);
            return;
        end
        check("hdr_ok_err", {31'd0, err}, 32'd0);
        img.delete();
        for (int i = 0; i < int'(n); i++) img.push_back($urandom);
        for (int i = 0; i < int'(n); i++) send_word(img[i], gap_max);
        check("last_we", {31'd0, mem_we}, 32'd1);
        check("last_done_early", {31'd0, done}, 32'd0);
        check("last_core_rst_early", {31'd0, core_rst}, 32'd1);
        @(posedge clk);
        #1;
        check("cmpl_done", {31'd0, done}, 32'd1);
        check("cmpl_core_rst", {31'd0, core_rst}, 32'd0);
        check("cmpl_ready", {31'd0, in_ready}, 32'd0);
        check("cmpl_we", {31'd0, mem_we}, 32'd0);
        check("cmpl_words", words_loaded, n);
        check("write_count", 32'(obs_addr.size()), n);
        for (int i = 0; i < int'(n) && i < obs_addr.size(); i++) begin
            check("write_addr", obs_addr[i], BASE + 32'(4 * i));
            check("write_data", obs_data[i], img[i]);
        end
    endtask

    typedef struct {
        logic [31:0] n;
        logic        exp_err;
        int          gap_max;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{n: 32'd0,          exp_err: 1'b1, gap_max: 0};
        vecs[1] = '{n: 32'd1,          exp_err: 1'b0, gap_max: 0};
        vecs[2] = '{n: 32'd4,          exp_err: 1'b0, gap_max: 1};
        vecs[3] = '{n: 32'd5,          exp_err: 1'b1, gap_max: 0};
        vecs[4] = '{n: 32'h0000_0104,  exp_err: 1'b1, gap_max: 0};
        vecs[5] = '{n: 32'h8000_0001,  exp_err: 1'b1, gap_max: 2};
        vecs[6] = '{n: 32'd3,          exp_err: 1'b0, gap_max: 3};

        for (int v = 0; v < 7; v++) begin
            do_reset();
            run_load(vecs[v].n, vecs[v].exp_err, vecs[v].gap_max);
        end

        // Nominal image, then input held after done.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h0050_0093, 0);
        send_word(32'h0010_8113, 0);
        @(posedge clk);
        #1;
        check("nom_count", 32'(obs_addr.size()), 32'd2);
        if (obs_addr.size() == 2) begin
            check("nom_addr0", obs_addr[0], 32'd4);
            check("nom_data0", obs_data[0], 32'h0050_0093);
            check("nom_addr1", obs_addr[1], 32'd8);
            check("nom_data1", obs_data[1], 32'h0010_8113);
        end
        check("nom_done", {31'd0, done}, 32'd1);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
            check("post_ready", {31'd0, in_ready}, 32'd0);
            check("post_we", {31'd0, mem_we}, 32'd0);
            check("post_done", {31'd0, done}, 32'd1);
            check("post_core_rst", {31'd0, core_rst}, 32'd0);
        end
        in_valid = 1'b0;
        check("post_words", words_loaded, 32'd2);
        check("post_count", 32'(obs_addr.size()), 32'd2);

        // Gapped stream: in_valid low for three cycles mid-word.
        do_reset();
        send_word(32'd2, 0);
        send_word(32'h0050_0093, 0);
        send_byte(8'h13, 0);
        send_byte(8'h81, 0);
        for (int c = 0; c < 3; c++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
            check("gap_we", {31'd0, mem_we}, 32'd0);
            check("gap_core_rst", {31'd0, core_rst}, 32'd1);
        end
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        check("gap_last_we", {31'd0, mem_we}, 32'd1);
        check("gap_last_addr", mem_addr, 32'd8);
        check("gap_last_data", mem_wdata, 32'h0010_8113);
        check("gap_core_rst_hold", {31'd0, core_rst}, 32'd1);
        @(posedge clk);
        #1;
        check("gap_done", {31'd0, done}, 32'd1);
        check("gap_count", 32'(obs_addr.size()), 32'd2);

        // Reset mid-word with a byte offered on the reset edge.
        do_reset();
        send_word(32'd3, 0);
        send_word(32'hDEAD_BEEF, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h33;
        @(posedge clk);
        #1;
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_words", words_loaded, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_core_rst", {31'd0, core_rst}, 32'd1);
        rst = 1'b0;
        in_valid = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        run_load(32'd1, 1'b0, 0);

        // Randomized images and headers against the rule-based reference.
        for (int r = 0; r < 20; r++) begin
            logic [31:0] n;
            n = (($urandom % 5) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom_range(1, MAXW));
            do_reset();
            run_load(n, (n == 32'd0) || (n > 32'(MAXW)), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the core's instruction memory. Accepts a byte stream (valid/ready), assembles little-endian 32-bit words, and writes them into instruction memory starting at byte address BASE_ADDR with a stride of 4. It holds the core in reset until the whole image has been written. This replaces the simulation-only hex-dump preload with a synthesizable path.

## Interface
- BASE_ADDR, 32'd4: byte address of the first instruction word written.
- MAX_WORDS, 1024: largest image accepted, in words.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a byte transfers on a clk edge with in_valid & in_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  word written.
- core_rst  out  1  reset to the core; high until the load completes.
- done  out  1  image fully loaded; sticky until rst.
- err  out  1  bad header; sticky until rst.
- words_loaded  out  32  number of words written so far.

## Operation
- Stream format: 4-byte header N (word count, little-endian), then N words of 4 bytes each, little-endian (first byte lands in bits [7:0]).
- States: HDR (collect header bytes), DATA (collect word bytes), DONE, ERR.
- Byte counter of 2 bits selects the byte lane and wraps 3→0 on each completed word or header.
- HDR: after the 4th header byte, next state is ERR if N == 0 or N > MAX_WORDS, else DATA.
- DATA: on the 4th byte of word k (0-based), issue one write with mem_addr = BASE_ADDR + 4*k and mem_wdata = the assembled word. words_loaded increments with that write. After the write for word N-1, go to DONE.
- DONE: in_ready=0, core_rst=0, done=1; further stream input is ignored (not accepted).
- ERR: in_ready=0, core_rst=1, err=1, no writes; exit only via rst.
- in_ready=1 in HDR and DATA, including the cycle carrying a mem_we, so there are no stalls.
- Address arithmetic is 32-bit unsigned. MAX_WORDS bounds it, so wrap-around cannot occur for legal parameters.

## Timing
- Reset values (cycle after rst sampled high): state=HDR, byte counter=0, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0, words_loaded=0.
- Write latency: if the 4th byte of a word is accepted at edge t, mem_we=1 with valid addr/data for exactly the cycle following t (registered outputs).
- Completion: if the last byte is accepted at edge t, mem_we follows t. done=1 and core_rst=0 from the second cycle after t onward, so core_rst falls one cycle after the last write is committed.
- Header error: if the 4th header byte is accepted at edge t, err=1 and in_ready=0 from the cycle following t.
- in_valid low mid-word: the partial word and counter hold indefinitely; no timeout.
- rst mid-load: synchronous; takes priority over any same-edge byte. The partial word is discarded, no mem_we is issued in the cycle after reset, and the state returns to HDR with words_loaded=0.
- mem_we is never high in two consecutive cycles (a minimum of 4 accepted bytes separates writes).

## Test plan
- Nominal: header 02 00 00 00, words 0x00500093, 0x00108113 streamed back-to-back → mem_we at addr 4 data 0x00500093, then addr 8 data 0x00108113. words_loaded=2. done=1 and core_rst=0 two cycles after the last byte.
- Gapped stream: same image with in_valid dropped for 3 cycles mid-word → identical writes; no extra mem_we; core_rst stays 1 until completion.
- Zero header: 00 00 00 00 → err=1 and in_ready=0 next cycle; no mem_we ever; core_rst stays 1.
- Oversize: MAX_WORDS=4, header 05 00 00 00 → err=1; no writes; a following rst restores HDR with err=0.
- Reset mid-word: N=3, rst asserted after 2 bytes of word 1 → no write for word 1, words_loaded=0. Re-streaming a full N=1 image writes addr 4 and reaches done.
- Post-done input: after done, hold in_valid=1 for 10 cycles → in_ready=0 throughout, no mem_we, done and core_rst unchanged.
